// File: rtl/alu_muldiv_seq.sv
// alu_muldiv_seq: multi-cycle unsigned 16x16 multiply and 16/16 divide
// sequencer. It borrows the shared combinational ALU for one ADD (multiply)
// or SUB (divide) iteration per clock and hands results back over a
// valid/ready handshake.
module alu_muldiv_seq #(
  parameter int                 DATA_W    = 16,
  parameter logic [DATA_W-1:0]  DIV0_QUOT = 16'hFFFF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_op,
  input  logic [DATA_W-1:0] in_a,
  input  logic [DATA_W-1:0] in_b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_hi,
  output logic [DATA_W-1:0] out_lo,
  output logic              out_div0,
  output logic              busy,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [2:0]        alu_op,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_carry
);

  localparam int CNT_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_W - 1);
  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state, state_next;
  logic [CNT_W-1:0]  count;
  logic              op_r;
  // hi_r holds H (multiply) or R (divide); lo_r holds L or Q; m_d holds M or D
  logic [DATA_W-1:0] hi_r, lo_r, m_d;
  logic [DATA_W-1:0] hi_next, lo_next;
  logic [DATA_W-1:0] t_val;
  logic              s_bit;
  logic              acc;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next state, handshake/ALU outputs and the per-iteration datapath update
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b0;
    alu_a      = '0;
    alu_b      = '0;
    alu_op     = OP_ADD;
    hi_next    = hi_r;
    lo_next    = lo_r;
    t_val      = '0;
    s_bit      = 1'b0;
    acc        = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_next = (in_op && in_b == '0) ? DONE : RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (!op_r) begin
          alu_a   = hi_r;
          alu_b   = lo_r[0] ? m_d : '0;
          alu_op  = OP_ADD;
          hi_next = {alu_carry, alu_result[DATA_W-1:1]};
          lo_next = {alu_result[0], lo_r[DATA_W-1:1]};
        end else begin
          // s is the bit shifted out of R; if set, T+2^16 >= D always holds
          s_bit   = hi_r[DATA_W-1];
          t_val   = {hi_r[DATA_W-2:0], lo_r[DATA_W-1]};
          alu_a   = t_val;
          alu_b   = m_d;
          alu_op  = OP_SUB;
          acc     = s_bit | ~alu_carry;
          hi_next = acc ? alu_result : t_val;
          lo_next = {lo_r[DATA_W-2:0], acc};
        end
        if (count == LAST_CNT) state_next = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        busy      = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Operand latch, iteration registers and result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      count    <= '0;
      op_r     <= 1'b0;
      hi_r     <= '0;
      lo_r     <= '0;
      m_d      <= '0;
      out_hi   <= '0;
      out_lo   <= '0;
      out_div0 <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            op_r  <= in_op;
            count <= '0;
            if (in_op && in_b == '0) begin
              out_lo   <= DIV0_QUOT;
              out_hi   <= in_a;
              out_div0 <= 1'b1;
            end else begin
              hi_r <= '0;
              lo_r <= in_op ? in_a : in_b;
              m_d  <= in_op ? in_b : in_a;
            end
          end
        end
        RUN: begin
          hi_r  <= hi_next;
          lo_r  <= lo_next;
          count <= count + 1'b1;
          if (count == LAST_CNT) begin
            out_hi   <= hi_next;
            out_lo   <= lo_next;
            out_div0 <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_muldiv_seq.sv
// tb_alu_muldiv_seq: directed scoreboard bench for alu_muldiv_seq. A small
// combinational ALU model sits on the alu_* ports; stimulus pushes expected
// results into a queue that a negedge monitor pops on each output handshake.
module tb_alu_muldiv_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic        in_op;
  logic [15:0] in_a, in_b;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_hi, out_lo;
  logic        out_div0;
  logic        busy;
  logic [15:0] alu_a, alu_b;
  logic [2:0]  alu_op;
  logic [15:0] alu_result;
  logic        alu_carry;

  typedef struct packed {
    logic [15:0] hi;
    logic [15:0] lo;
    logic        div0;
  } exp_t;

  exp_t sb[$];
  int   tests_run    = 0;
  int   tests_failed = 0;

  alu_muldiv_seq dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_hi(out_hi), .out_lo(out_lo), .out_div0(out_div0),
    .busy(busy),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_result(alu_result), .alu_carry(alu_carry)
  );

  always #5 clk = ~clk;

  // Reference ALU: ADD gives carry-out, SUB gives borrow in alu_carry
  always_comb begin
    logic [16:0] r;
    r = 17'd0;
    case (alu_op)
      3'b000:  r = {1'b0, alu_a} + {1'b0, alu_b};
      3'b001:  r = {1'b0, alu_a} - {1'b0, alu_b};
      default: r = 17'd0;
    endcase
    alu_result = r[15:0];
    alu_carry  = r[16];
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: pops the scoreboard on every result handshake
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        checkOutput("unexpected_result", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        checkOutput("out_hi", 32'(out_hi), 32'(e.hi));
        checkOutput("out_lo", 32'(out_lo), 32'(e.lo));
        checkOutput("out_div0", 32'(out_div0), 32'(e.div0));
      end
    end
  end

  // Issue one op, track latency and ALU op per cycle, optionally stall in DONE
  task automatic applyStimulus(input logic op, input logic [15:0] a, input logic [15:0] b,
                               input logic [15:0] exp_hi, input logic [15:0] exp_lo,
                               input logic exp_div0, input int exp_lat, input int hold);
    int wait_cnt;
    int lat;
    wait_cnt = 0;
    while (!in_ready && wait_cnt < 50) begin
      step();
      wait_cnt++;
    end
    if (!in_ready) begin
      checkOutput("in_ready_timeout", 32'd0, 32'd1);
      return;
    end
    in_valid = 1'b1;
    in_op    = op;
    in_a     = a;
    in_b     = b;
    sb.push_back('{hi: exp_hi, lo: exp_lo, div0: exp_div0});
    step();
    in_valid = 1'b0;
    in_a     = 16'($urandom);
    in_b     = 16'($urandom);
    lat = 1;
    while (!out_valid && lat < 40) begin
      checkOutput("alu_op_run", 32'(alu_op), op ? 32'd1 : 32'd0);
      step();
      lat++;
    end
    checkOutput("latency", 32'(lat), 32'(exp_lat));
    checkOutput("alu_op_done", 32'(alu_op), 32'd0);
    for (int i = 0; i < hold; i++) begin
      step();
      checkOutput("hold_valid", 32'(out_valid), 32'd1);
      checkOutput("hold_in_ready", 32'(in_ready), 32'd0);
      checkOutput("hold_hi", 32'(out_hi), 32'(exp_hi));
      checkOutput("hold_lo", 32'(out_lo), 32'(exp_lo));
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    checkOutput("post_in_ready", 32'(in_ready), 32'd1);
    checkOutput("post_out_valid", 32'(out_valid), 32'd0);
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_op     = 1'b0;
    in_a      = 16'h0;
    in_b      = 16'h0;
    out_ready = 1'b0;
    step();
    step();
    rst = 1'b0;
    checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_out_hi", 32'(out_hi), 32'd0);
    checkOutput("rst_out_lo", 32'(out_lo), 32'd0);
    checkOutput("rst_out_div0", 32'(out_div0), 32'd0);
    checkOutput("rst_alu", {13'd0, alu_op, alu_a}, 32'd0);
    checkOutput("rst_alu_b", 32'(alu_b), 32'd0);

    applyStimulus(1'b0, 16'd3, 16'd5, 16'h0000, 16'h000F, 1'b0, 17, 0);
    applyStimulus(1'b0, 16'hFFFF, 16'hFFFF, 16'hFFFE, 16'h0001, 1'b0, 17, 0);
    applyStimulus(1'b0, 16'h1234, 16'h0100, 16'h0012, 16'h3400, 1'b0, 17, 0);
    applyStimulus(1'b1, 16'd100, 16'd7, 16'h0002, 16'h000E, 1'b0, 17, 5);
    applyStimulus(1'b1, 16'hFFFF, 16'h8001, 16'h7FFE, 16'h0001, 1'b0, 17, 0);
    applyStimulus(1'b1, 16'h8000, 16'h0003, 16'h0002, 16'h2AAA, 1'b0, 17, 0);
    applyStimulus(1'b1, 16'h1234, 16'h0000, 16'h1234, 16'hFFFF, 1'b1, 1, 2);

    // Reset while RUN is at count 8: accept cycle 0, count 8 is cycle 9
    in_valid = 1'b1;
    in_op    = 1'b0;
    in_a     = 16'h00FF;
    in_b     = 16'h00FF;
    step();
    in_valid = 1'b0;
    for (int i = 1; i < 9; i++) step();
    checkOutput("mid_run_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    checkOutput("midrst_in_ready", 32'(in_ready), 32'd1);
    checkOutput("midrst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("midrst_busy", 32'(busy), 32'd0);
    checkOutput("midrst_out_lo", 32'(out_lo), 32'd0);
    checkOutput("midrst_alu_op", 32'(alu_op), 32'd0);
    applyStimulus(1'b0, 16'd2, 16'd2, 16'h0000, 16'h0004, 1'b0, 17, 0);

    step();
    checkOutput("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
